// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: control FSM handshake, PC unit hookup, memory read port and IR results.
// slave is the fetch unit's view; master is the surrounding datapath's view.
interface instr_fetch_unit_if #(
    parameter int WIDTH = 16
);
    logic             Fetch_Start;
    logic             Flush;
    logic [WIDTH-1:0] PC_In;
    logic [WIDTH-1:0] Mem_Rdata;
    logic             Mem_Ready;
    logic             LD_PC;
    logic [1:0]       Sel_PC;
    logic             Mem_Req;
    logic [WIDTH-1:0] Mem_Addr;
    logic [WIDTH-1:0] IR_Out;
    logic [WIDTH-1:0] Fetched_PC;
    logic             Fetch_Done;
    logic             Busy;
    logic             Fetch_Err;

    modport slave (
        input  Fetch_Start, Flush, PC_In, Mem_Rdata, Mem_Ready,
        output LD_PC, Sel_PC, Mem_Req, Mem_Addr, IR_Out, Fetched_PC,
               Fetch_Done, Busy, Fetch_Err
    );

    modport master (
        output Fetch_Start, Flush, PC_In, Mem_Rdata, Mem_Ready,
        input  LD_PC, Sel_PC, Mem_Req, Mem_Addr, IR_Out, Fetched_PC,
               Fetch_Done, Busy, Fetch_Err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// SLC-3 instruction fetch sequencer: latch PC into MAR, bump the PC, run a
// variable-latency memory read into IR, with flush and optional timeout.
module instr_fetch_unit #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input logic               Clk,
    input logic               Reset,
    instr_fetch_unit_if.slave bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0] TO_LIMIT = TIMEOUT[CW:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mar;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] fpc_q;
    logic [CW-1:0]    wait_cnt;
    logic             mem_req_q;
    logic             done_q;
    logic             busy_q;
    logic             err_q;

    logic             accept;
    logic [CW:0]      wait_next;
    logic             timeout_hit;

    // LD_PC must fire in the accept cycle itself so the PC increments on the same edge
    assign accept = (state == S_IDLE) && bus.Fetch_Start && !bus.Flush;

    always_comb begin
        wait_next   = {1'b0, wait_cnt} + {{CW{1'b0}}, 1'b1};
        timeout_hit = (TIMEOUT != 0) && (wait_next >= TO_LIMIT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            mar       <= '0;
            ir_q      <= '0;
            fpc_q     <= '0;
            wait_cnt  <= '0;
            mem_req_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        mar       <= bus.PC_In;
                        wait_cnt  <= '0;
                        err_q     <= 1'b0;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // priority: flush, then read completion, then timeout
                    if (bus.Flush) begin
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state     <= S_IDLE;
                    end else if (bus.Mem_Ready) begin
                        ir_q      <= bus.Mem_Rdata;
                        fpc_q     <= mar;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= S_DONE;
                    end else if (timeout_hit) begin
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state     <= S_IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_next[CW-1:0];
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.LD_PC      = accept;
    assign bus.Sel_PC     = accept ? 2'b00 : 2'b11;
    assign bus.Mem_Req    = mem_req_q;
    assign bus.Mem_Addr   = mar;
    assign bus.IR_Out     = ir_q;
    assign bus.Fetched_PC = fpc_q;
    assign bus.Fetch_Done = done_q;
    assign bus.Busy       = busy_q;
    assign bus.Fetch_Err  = err_q;
endmodule
